// File: rtl/axis_upsizer.sv
// axis_upsizer: packs RATIO narrow AXI-Stream beats into one wide beat with a
// per-lane keep mask. s_tlast closes the wide word early so packets never
// share a wide beat. Also counts delivered packets (m_tlast handshakes).
module axis_upsizer #(
    parameter int DW    = 8,
    parameter int RATIO = 4,
    parameter int CW    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DW-1:0]         s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    output logic [DW*RATIO-1:0]   m_tdata,
    output logic [RATIO-1:0]      m_tkeep,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [CW-1:0]         pkt_count
);

    localparam int CNTW = $clog2(RATIO);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(RATIO - 1);

    // Assembly register, lane counter and output register
    logic [DW*RATIO-1:0] asm_data_q, asm_data_d;
    logic [RATIO-1:0]    asm_keep_q, asm_keep_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [DW*RATIO-1:0] out_data_q, out_data_d;
    logic [RATIO-1:0]    out_keep_q, out_keep_d;
    logic                out_last_q, out_last_d;
    logic                out_valid_q, out_valid_d;
    logic [CW-1:0]       pkt_q, pkt_d;

    // Assembly contents with the current beat inserted at lane cnt
    logic [DW*RATIO-1:0] merged_data;
    logic [RATIO-1:0]    merged_keep;

    logic accept;
    logic complete;

    assign s_tready = !out_valid_q || m_tready;
    assign accept   = s_tvalid && s_tready;
    assign complete = accept && ((cnt_q == CNT_LAST) || s_tlast);

    // Merge the incoming beat into its lane. Lanes above cnt are still zero in
    // the assembly register, so unused lanes of a short word come out as zero.
    always_comb begin
        merged_data = asm_data_q;
        merged_keep = asm_keep_q;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (CNTW'(i) == cnt_q) begin
                merged_data[i*DW +: DW] = s_tdata;
                merged_keep[i]          = 1'b1;
            end
        end
    end

    // Next-state: assembly/lane counter update, output load/drain, packet count
    always_comb begin
        asm_data_d  = asm_data_q;
        asm_keep_d  = asm_keep_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        pkt_d       = pkt_q;

        if (out_valid_q && m_tready) begin
            out_valid_d = 1'b0;
            if (out_last_q) begin
                pkt_d = pkt_q + 1'b1;
            end
        end

        // A load in the same cycle as a drain overrides the drain
        if (complete) begin
            out_data_d  = merged_data;
            out_keep_d  = merged_keep;
            out_last_d  = s_tlast;
            out_valid_d = 1'b1;
            asm_data_d  = '0;
            asm_keep_d  = '0;
            cnt_d       = '0;
        end else if (accept) begin
            asm_data_d = merged_data;
            asm_keep_d = merged_keep;
            cnt_d      = cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset; partial words are discarded
    always_ff @(posedge clock) begin
        if (reset) begin
            asm_data_q  <= '0;
            asm_keep_q  <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            pkt_q       <= '0;
        end else begin
            asm_data_q  <= asm_data_d;
            asm_keep_q  <= asm_keep_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            pkt_q       <= pkt_d;
        end
    end

    assign m_tdata   = out_data_q;
    assign m_tkeep   = out_keep_q;
    assign m_tlast   = out_last_q;
    assign m_tvalid  = out_valid_q;
    assign pkt_count = pkt_q;

endmodule
